// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode constants, receiver state encoding
// and small bit-level helpers used by the receive path.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    // Two-of-three vote used to recover a bit from its three mid-bit samples.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // xor_all is the XOR of the data bits and the received parity bit.
    function automatic logic parity_error(input int mode, input logic xor_all);
        logic err;
        case (mode)
            PARITY_EVEN: err = xor_all;
            PARITY_ODD:  err = ~xor_all;
            default:     err = 1'b0;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an idle-high asynchronous serial line.
// Both flops reset to 1 so that reset never looks like a start bit.
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    // Double-register the asynchronous input into the clk domain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: oversampled majority-vote bit recovery, configurable frame
// format, and a one-cycle valid pulse carrying the word and error flags.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int MSB_FIRST  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_in,
    input  logic                 tick,
    output logic [DATA_BITS-1:0] dout,
    output logic                 valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 busy
);

    localparam int M  = OVERSAMPLE / 2;
    localparam int CW = $clog2(OVERSAMPLE);

    localparam logic [CW-1:0] CNT_SAMP0 = CW'(M - 1);
    localparam logic [CW-1:0] CNT_SAMP1 = CW'(M);
    localparam logic [CW-1:0] CNT_DEC   = CW'(M + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(OVERSAMPLE - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    logic                 w_rx;
    logic                 w_bit;
    logic                 w_decide;
    logic                 w_wrap;
    logic                 w_done;

    rx_state_e            r_state,    w_state_nxt;
    logic [CW-1:0]        r_cnt,      w_cnt_nxt;
    logic [3:0]           r_bit_cnt,  w_bit_nxt;
    logic [1:0]           r_samp,     w_samp_nxt;
    logic [DATA_BITS-1:0] r_shift,    w_shift_nxt;
    logic                 r_par,      w_par_nxt;
    logic                 r_stop_err, w_serr_nxt;
    logic                 r_all_zero, w_zero_nxt;

    logic [DATA_BITS-1:0] r_dout;
    logic                 r_valid;
    logic                 r_perr;
    logic                 r_ferr;
    logic                 r_brk;
    logic                 r_busy;

    uart_rx_sync u_sync (
        .clk     (clk),
        .reset   (reset),
        .i_async (rx_in),
        .o_sync  (w_rx)
    );

    // Samples at M-1 and M are stored; the M+1 sample is the live line value.
    assign w_bit    = maj3(r_samp[1], r_samp[0], w_rx);
    assign w_decide = (r_cnt == CNT_DEC);
    assign w_wrap   = (r_cnt == CNT_LAST);

    // Next-state logic: everything advances only on a tick.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_samp_nxt  = r_samp;
        w_shift_nxt = r_shift;
        w_par_nxt   = r_par;
        w_serr_nxt  = r_stop_err;
        w_zero_nxt  = r_all_zero;
        w_done      = 1'b0;
        if (tick) begin
            if (r_state == ST_IDLE) begin
                if (!w_rx) begin
                    // This tick is count 0 of the start bit.
                    w_state_nxt = ST_START;
                    w_cnt_nxt   = CW'(1);
                    w_bit_nxt   = 4'd0;
                    w_par_nxt   = 1'b0;
                    w_serr_nxt  = 1'b0;
                    w_zero_nxt  = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end else begin
                w_cnt_nxt = w_wrap ? CW'(0) : (r_cnt + CW'(1));
                if (r_cnt == CNT_SAMP0) begin
                    w_samp_nxt[1] = w_rx;
                end else if (r_cnt == CNT_SAMP1) begin
                    w_samp_nxt[0] = w_rx;
                end else begin
                    w_samp_nxt = r_samp;
                end
                case (r_state)
                    ST_START: begin
                        if (w_decide && w_bit) begin
                            w_state_nxt = ST_IDLE;
                            w_cnt_nxt   = CW'(0);
                        end else if (w_wrap) begin
                            w_state_nxt = ST_DATA;
                            w_bit_nxt   = 4'd0;
                        end else begin
                            w_state_nxt = ST_START;
                        end
                    end
                    ST_DATA: begin
                        if (w_decide) begin
                            if (MSB_FIRST != 0) begin
                                w_shift_nxt = {r_shift[DATA_BITS-2:0], w_bit};
                            end else begin
                                w_shift_nxt = {w_bit, r_shift[DATA_BITS-1:1]};
                            end
                            w_par_nxt  = r_par ^ w_bit;
                            w_zero_nxt = r_all_zero & ~w_bit;
                        end else if (w_wrap) begin
                            if (r_bit_cnt == DATA_LAST) begin
                                w_bit_nxt   = 4'd0;
                                w_state_nxt = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                            end else begin
                                w_bit_nxt = r_bit_cnt + 4'd1;
                            end
                        end else begin
                            w_state_nxt = ST_DATA;
                        end
                    end
                    ST_PARITY: begin
                        if (w_decide) begin
                            w_par_nxt  = r_par ^ w_bit;
                            w_zero_nxt = r_all_zero & ~w_bit;
                        end else if (w_wrap) begin
                            w_state_nxt = ST_STOP;
                            w_bit_nxt   = 4'd0;
                        end else begin
                            w_state_nxt = ST_PARITY;
                        end
                    end
                    ST_STOP: begin
                        if (w_decide) begin
                            w_serr_nxt = r_stop_err | ~w_bit;
                            w_zero_nxt = r_all_zero & ~w_bit;
                            // Leave at the last decision so a following start edge is caught.
                            if (r_bit_cnt == STOP_LAST) begin
                                w_state_nxt = ST_IDLE;
                                w_cnt_nxt   = CW'(0);
                                w_done      = 1'b1;
                            end else begin
                                w_state_nxt = ST_STOP;
                            end
                        end else if (w_wrap) begin
                            w_bit_nxt = r_bit_cnt + 4'd1;
                        end else begin
                            w_state_nxt = ST_STOP;
                        end
                    end
                    default: begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = CW'(0);
                    end
                endcase
            end
        end else begin
            w_done = 1'b0;
        end
    end

    // Receiver state, counters and shift register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= CW'(0);
            r_bit_cnt  <= 4'd0;
            r_samp     <= 2'b00;
            r_shift    <= {DATA_BITS{1'b0}};
            r_par      <= 1'b0;
            r_stop_err <= 1'b0;
            r_all_zero <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_samp     <= w_samp_nxt;
            r_shift    <= w_shift_nxt;
            r_par      <= w_par_nxt;
            r_stop_err <= w_serr_nxt;
            r_all_zero <= w_zero_nxt;
        end
    end

    // Output registers: word and flags load together with the valid pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dout  <= {DATA_BITS{1'b0}};
            r_valid <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_brk   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_valid <= w_done;
            r_busy  <= (w_state_nxt != ST_IDLE);
            if (w_done) begin
                r_dout <= w_shift_nxt;
                r_perr <= parity_error(PARITY, w_par_nxt);
                r_ferr <= w_serr_nxt;
                r_brk  <= w_zero_nxt;
            end
        end
    end

    assign dout       = r_dout;
    assign valid      = r_valid;
    assign parity_err = r_perr;
    assign frame_err  = r_ferr;
    assign break_det  = r_brk;
    assign busy       = r_busy;

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: three instances (8N1 MSB-first,
// 8E1 MSB-first, 8N2 LSB-first) driven by per-tick line values built from
// whole frames, checked against expectations derived from the frame contents.
`timescale 1ns/1ps
module tb_uart_rx_core;

    localparam int OS = 16;
    localparam int M  = OS / 2;
    localparam int DB = 8;
    localparam int CFG_PAR  [0:2] = '{0, 2, 0};
    localparam int CFG_STOP [0:2] = '{1, 1, 2};
    localparam int CFG_MSB  [0:2] = '{1, 1, 0};

    logic          clk = 1'b0;
    logic          reset;
    logic          tick;
    logic          rx      [0:2];
    logic [DB-1:0] dout_w  [0:2];
    logic          valid_w [0:2];
    logic          perr_w  [0:2];
    logic          ferr_w  [0:2];
    logic          brk_w   [0:2];
    logic          busy_w  [0:2];

    int n_cmp  = 0;
    int n_fail = 0;
    int pulses [0:2] = '{0, 0, 0};

    int            obs_tick;
    int            obs_nv;
    logic [DB-1:0] obs_dout;
    logic          obs_perr;
    logic          obs_ferr;
    logic          obs_brk;

    uart_rx_core #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1), .MSB_FIRST(1)) u_dut_a (
        .clk(clk), .reset(reset), .rx_in(rx[0]), .tick(tick), .dout(dout_w[0]), .valid(valid_w[0]),
        .parity_err(perr_w[0]), .frame_err(ferr_w[0]), .break_det(brk_w[0]), .busy(busy_w[0]));
    uart_rx_core #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(2), .STOP_BITS(1), .MSB_FIRST(1)) u_dut_b (
        .clk(clk), .reset(reset), .rx_in(rx[1]), .tick(tick), .dout(dout_w[1]), .valid(valid_w[1]),
        .parity_err(perr_w[1]), .frame_err(ferr_w[1]), .break_det(brk_w[1]), .busy(busy_w[1]));
    uart_rx_core #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(2), .MSB_FIRST(0)) u_dut_c (
        .clk(clk), .reset(reset), .rx_in(rx[2]), .tick(tick), .dout(dout_w[2]), .valid(valid_w[2]),
        .parity_err(perr_w[2]), .frame_err(ferr_w[2]), .break_det(brk_w[2]), .busy(busy_w[2]));

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Count every clk cycle a valid is high, per instance.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (valid_w[i] === 1'b1) pulses[i] <= pulses[i] + 1;
        end
    end

    // One oversample tick: line settles 3 clks ahead, tick high for one edge.
    task automatic do_tick(input int w, input logic v, input int k);
        rx[w] = v;
        repeat (3) @(posedge clk);
        #1 tick = 1'b1;
        @(posedge clk);
        #1 tick = 1'b0;
        if (valid_w[w] === 1'b1) begin
            if (obs_nv == 0) begin
                obs_tick = k;
                obs_dout = dout_w[w];
                obs_perr = perr_w[w];
                obs_ferr = ferr_w[w];
                obs_brk  = brk_w[w];
            end
            obs_nv++;
        end
    endtask

    task automatic idle(input int w, input int n);
        for (int i = 0; i < n; i++) do_tick(w, 1'b1, -1);
    endtask

    // Send one whole frame; glitch >= 0 inverts the count-M sample of that data bit.
    task automatic send_frame(input int w, input logic [DB-1:0] word, input logic pbit,
                              input logic [1:0] stops, input int glitch);
        logic bits [$];
        int   k;
        logic v;
        k = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < DB; i++) bits.push_back((CFG_MSB[w] != 0) ? word[DB-1-i] : word[i]);
        if (CFG_PAR[w] != 0) bits.push_back(pbit);
        for (int s = 0; s < CFG_STOP[w]; s++) bits.push_back(stops[s]);
        obs_tick = -1; obs_nv = 0; obs_dout = '0; obs_perr = 1'b0; obs_ferr = 1'b0; obs_brk = 1'b0;
        for (int j = 0; j < bits.size(); j++) begin
            for (int c = 0; c < OS; c++) begin
                v = bits[j];
                if (glitch >= 0 && j == glitch + 1 && c == M) v = ~v;
                do_tick(w, v, k);
                k++;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; tick = 1'b0;
        for (int i = 0; i < 3; i++) rx[i] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (dout_w[0] !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h want 00", dout_w[0]); end
        n_cmp++; if (valid_w[0] !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_w[0]); end
        n_cmp++; if ({perr_w[0], ferr_w[0], brk_w[0]} !== 3'b000) begin n_fail++;
            $display("FAIL reset_flags: got %b%b%b want 000", perr_w[0], ferr_w[0], brk_w[0]); end
        n_cmp++; if ({busy_w[0], busy_w[1], busy_w[2]} !== 3'b000) begin n_fail++;
            $display("FAIL reset_busy: got %b%b%b want 000", busy_w[0], busy_w[1], busy_w[2]); end
        reset = 1'b1;
        idle(0, 4);
    endtask

    task automatic test_glitch_8n1;
        int p;
        p = pulses[0];
        send_frame(0, 8'hA5, 1'b0, 2'b11, 3);
        n_cmp++; if (obs_tick !== 153) begin n_fail++; $display("FAIL glitch_latency: got tick %0d want 153", obs_tick); end
        n_cmp++; if (pulses[0] - p !== 1) begin n_fail++; $display("FAIL glitch_pulses: got %0d want 1", pulses[0] - p); end
        n_cmp++; if (obs_dout !== 8'hA5) begin n_fail++; $display("FAIL glitch_dout: got %h want a5", obs_dout); end
        n_cmp++; if ({obs_perr, obs_ferr, obs_brk} !== 3'b000) begin n_fail++;
            $display("FAIL glitch_flags: got %b%b%b want 000", obs_perr, obs_ferr, obs_brk); end
        idle(0, 20);
    endtask

    task automatic test_parity;
        send_frame(1, 8'h3C, 1'b1, 2'b11, -1);
        n_cmp++; if (obs_nv !== 1) begin n_fail++; $display("FAIL parity_valid: got %0d want 1", obs_nv); end
        n_cmp++; if (obs_tick !== 169) begin n_fail++; $display("FAIL parity_latency: got %0d want 169", obs_tick); end
        n_cmp++; if (obs_dout !== 8'h3C) begin n_fail++; $display("FAIL parity_dout: got %h want 3c", obs_dout); end
        n_cmp++; if ({obs_perr, obs_ferr} !== 2'b10) begin n_fail++;
            $display("FAIL parity_bad_flags: got perr=%b ferr=%b want 1 0", obs_perr, obs_ferr); end
        idle(1, 20);
        send_frame(1, 8'h3C, 1'b0, 2'b11, -1);
        n_cmp++; if (obs_perr !== 1'b0) begin n_fail++; $display("FAIL parity_good: got perr=%b want 0", obs_perr); end
        idle(1, 20);
    endtask

    task automatic test_frame_break;
        send_frame(0, 8'h55, 1'b0, 2'b00, -1);
        n_cmp++; if ({obs_ferr, obs_brk} !== 2'b10) begin n_fail++;
            $display("FAIL stop_low: got ferr=%b brk=%b want 1 0", obs_ferr, obs_brk); end
        n_cmp++; if (obs_dout !== 8'h55) begin n_fail++; $display("FAIL stop_low_dout: got %h want 55", obs_dout); end
        idle(0, 20);
        send_frame(0, 8'h00, 1'b0, 2'b00, -1);
        n_cmp++; if ({obs_ferr, obs_brk} !== 2'b11) begin n_fail++;
            $display("FAIL break: got ferr=%b brk=%b want 1 1", obs_ferr, obs_brk); end
        n_cmp++; if (obs_nv !== 1 || obs_dout !== 8'h00) begin n_fail++;
            $display("FAIL break_dout: got nv=%0d dout=%h want 1 00", obs_nv, obs_dout); end
        idle(0, 20);
    endtask

    task automatic test_false_start;
        int p;
        p = pulses[0];
        for (int t = 0; t < 4; t++) do_tick(0, 1'b0, -1);
        for (int t = 4; t < 9; t++) do_tick(0, 1'b1, -1);
        n_cmp++; if (busy_w[0] !== 1'b1) begin n_fail++; $display("FAIL false_busy_hold: got %b want 1", busy_w[0]); end
        do_tick(0, 1'b1, -1);
        n_cmp++; if (busy_w[0] !== 1'b0) begin n_fail++; $display("FAIL false_busy_drop: got %b want 0", busy_w[0]); end
        idle(0, 10);
        n_cmp++; if (pulses[0] !== p) begin n_fail++; $display("FAIL false_no_valid: got %0d pulses want 0", pulses[0] - p); end
        send_frame(0, 8'h3C, 1'b0, 2'b11, -1);
        n_cmp++; if (obs_nv !== 1 || obs_dout !== 8'h3C || obs_ferr !== 1'b0) begin n_fail++;
            $display("FAIL false_next: got nv=%0d dout=%h ferr=%b want 1 3c 0", obs_nv, obs_dout, obs_ferr); end
        idle(0, 20);
    endtask

    task automatic test_reset_midframe;
        int            p;
        logic [DB-1:0] word;
        p = pulses[0];
        word = 8'h5A;
        for (int c = 0; c < OS; c++) do_tick(0, 1'b0, -1);
        for (int i = 0; i < 4; i++)
            for (int c = 0; c < OS; c++) do_tick(0, word[DB-1-i], -1);
        for (int c = 0; c < 5; c++) do_tick(0, word[DB-5], -1);
        reset = 1'b0;
        #2;
        n_cmp++; if (dout_w[0] !== 8'h00 || busy_w[0] !== 1'b0 || valid_w[0] !== 1'b0) begin n_fail++;
            $display("FAIL midreset_outputs: got dout=%h busy=%b valid=%b want 00 0 0", dout_w[0], busy_w[0], valid_w[0]); end
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        rx[0] = 1'b1;
        idle(0, 20);
        n_cmp++; if (pulses[0] !== p) begin n_fail++; $display("FAIL midreset_no_valid: got %0d pulses want 0", pulses[0] - p); end
        send_frame(0, 8'h81, 1'b0, 2'b11, -1);
        n_cmp++; if (obs_nv !== 1 || obs_dout !== 8'h81 || {obs_perr, obs_ferr, obs_brk} !== 3'b000) begin n_fail++;
            $display("FAIL midreset_next: got nv=%0d dout=%h flags=%b%b%b want 1 81 000", obs_nv, obs_dout, obs_perr, obs_ferr, obs_brk); end
        idle(0, 20);
    endtask

    task automatic test_back_to_back;
        int            p;
        logic [DB-1:0] d1;
        logic          e1;
        p = pulses[2];
        send_frame(2, 8'h12, 1'b0, 2'b11, -1);
        d1 = obs_dout;
        e1 = obs_ferr | obs_brk | obs_perr;
        n_cmp++; if (obs_tick !== 169) begin n_fail++; $display("FAIL b2b_latency: got %0d want 169", obs_tick); end
        send_frame(2, 8'h34, 1'b0, 2'b11, -1);
        n_cmp++; if (d1 !== 8'h12 || e1 !== 1'b0) begin n_fail++; $display("FAIL b2b_first: got %h err=%b want 12 0", d1, e1); end
        n_cmp++; if (obs_dout !== 8'h34 || (obs_ferr | obs_brk | obs_perr) !== 1'b0) begin n_fail++;
            $display("FAIL b2b_second: got %h ferr=%b want 34 0", obs_dout, obs_ferr); end
        n_cmp++; if (pulses[2] - p !== 2) begin n_fail++; $display("FAIL b2b_pulses: got %0d want 2", pulses[2] - p); end
        idle(2, 20);
    endtask

    task automatic test_random;
        int            w, g, p, exp_tick;
        logic [DB-1:0] word;
        logic          pbit, exp_perr, exp_ferr, exp_brk;
        logic [1:0]    stops;
        for (int n = 0; n < 12; n++) begin
            w     = int'($urandom_range(0, 2));
            word  = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            pbit  = 1'($urandom);
            stops = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b11;
            g     = int'($urandom_range(0, 8)) - 1;
            exp_perr = (CFG_PAR[w] == 2) ? (^word ^ pbit) : (CFG_PAR[w] == 1) ? ~(^word ^ pbit) : 1'b0;
            exp_ferr = (stops[0] == 1'b0) || (CFG_STOP[w] == 2 && stops[1] == 1'b0);
            exp_brk  = (word == 8'h00) && (CFG_PAR[w] == 0 || pbit == 1'b0) && (stops[0] == 1'b0)
                       && (CFG_STOP[w] == 1 || stops[1] == 1'b0);
            exp_tick = (DB + ((CFG_PAR[w] != 0) ? 1 : 0) + CFG_STOP[w]) * OS + M + 1;
            p = pulses[w];
            send_frame(w, word, pbit, stops, g);
            n_cmp++; if (obs_tick !== exp_tick || obs_dout !== word) begin n_fail++;
                $display("FAIL rnd%0d_word: dut%0d got tick=%0d dout=%h want %0d %h", n, w, obs_tick, obs_dout, exp_tick, word); end
            n_cmp++; if ({obs_perr, obs_ferr, obs_brk} !== {exp_perr, exp_ferr, exp_brk}) begin n_fail++;
                $display("FAIL rnd%0d_flags: dut%0d got %b%b%b want %b%b%b", n, w, obs_perr, obs_ferr, obs_brk, exp_perr, exp_ferr, exp_brk); end
            idle(w, 20);
            n_cmp++; if (pulses[w] - p !== 1) begin n_fail++; $display("FAIL rnd%0d_pulses: got %0d want 1", n, pulses[w] - p); end
        end
    endtask

    // Scenario sequence and summary.
    initial begin
        test_reset();
        test_glitch_8n1();
        test_parity();
        test_frame_break();
        test_false_start();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Parametrised UART receiver core with oversampled majority-vote bit recovery, configurable frame format and per-frame error reporting. It sits behind the shared baud-rate tick generator, samples the serial line on `tick` strobes, and presents each received word on a one-cycle `valid` pulse to the downstream tester or consumer logic.

## Interface
- `DATA_BITS`, 8: data bits per frame, legal range 5..9.
- `OVERSAMPLE`, 16: ticks per bit period; even, ≥ 4.
- `PARITY`, 0: parity mode, 0 none, 1 odd, 2 even.
- `STOP_BITS`, 1: number of stop bits, 1 or 2.
- `MSB_FIRST`, 1: 1 places the first data bit in `dout[DATA_BITS-1]`; 0 places it in `dout[0]`.

- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `rx_in` in 1: asynchronous serial line, idle high.
- `tick` in 1: oversample strobe, one `clk` cycle wide.
- `dout` out DATA_BITS: last received word.
- `valid` out 1: one-cycle pulse marking a completed frame.
- `parity_err` out 1: parity mismatch in the last frame.
- `frame_err` out 1: a stop bit sampled low in the last frame.
- `break_det` out 1: the whole frame was low.
- `busy` out 1: high while a frame is in progress.

## Operation
- `rx_in` passes through a 2-flop synchronizer. Both flops reset to 1. All decisions use the synchronized value.
- The bit-phase counter runs 0..OVERSAMPLE-1 and advances only on `tick`. With no tick, all state holds.
- Samples are taken at counts M-1, M and M+1, where M = OVERSAMPLE/2. The bit value is the majority of the three samples and is decided on the tick at count M+1.
- States:
  - IDLE: a tick with line low moves to START. That tick is count 0.
  - START: at the decision point, a majority of 1 is a false start; return to IDLE with no output. Otherwise move to DATA at count OVERSAMPLE-1.
  - DATA: receive DATA_BITS bits, then move to PARITY if PARITY≠0, else to STOP.
  - PARITY: decide one bit, then move to STOP.
  - STOP: decide STOP_BITS bits. Any stop bit deciding 0 sets the frame_err condition. At the last stop bit's decision point, return to IDLE immediately without waiting for the end of the bit, so a following start edge is caught.
- Shift direction is set by MSB_FIRST.
- Parity checks the data bits plus the parity bit:
  - Even: the XOR must be 0.
  - Odd: the XOR must be 1.
- break_det requires all data bits 0, the parity bit 0 (if present) and the stop bit(s) 0. break_det implies frame_err.
- A frame with errors still produces `valid`. Errors never suppress output.
- `busy` = state ≠ IDLE.

## Timing
- Reset values: `dout`=0, `valid`=0, `parity_err`=0, `frame_err`=0, `break_det`=0, `busy`=0, state IDLE, counters 0.
- `dout` and the three error flags update on the same edge that raises `valid`. They hold until the next `valid`.
- `valid` rises on the `clk` edge after the last stop-bit decision tick is sampled, and stays high for exactly one cycle.
- Tick latency from the first low tick (count 0) to the decision tick is (DATA_BITS + P + STOP_BITS)·OVERSAMPLE + M + 1 ticks, where P = 1 if PARITY≠0, else 0. For 8N1 at OVERSAMPLE=16 this is 153 ticks.
- Synchronizer latency: 2 `clk` cycles from `rx_in` to first visibility.
- Reset asserted mid-frame aborts the frame immediately. No `valid` is produced. After release, the core waits for a fresh start bit.
- A line that is still low when returning to IDLE is treated as a new start on the next tick.

## Structure
- Shared package `uart_pkg` holds:
  - Parity constants PARITY_NONE=0, PARITY_ODD=1, PARITY_EVEN=2.
  - The receiver state enum (IDLE, START, DATA, PARITY, STOP).
- One sub-module, `uart_rx_sync`: the 2-flop reset-to-1 synchronizer, reusable by the transmit-side loopback.
- Majority vote, counters and shift register stay in `uart_rx_core`.

## Test plan
1. 8N1, OVERSAMPLE=16, MSB_FIRST=1. Send 0xA5, with one sample in bit 3 inverted at count M. Required: a single `valid` at tick 153+1 clk, `dout`=0xA5, all error flags 0.
2. Drive the line low for 4 ticks, then high. Required: no `valid`, `busy` falls after the tick at count M+1, the next 0x3C frame is received correctly.
3. PARITY=2. Send 0x3C with parity bit 1. Required: `valid`, `dout`=0x3C, `parity_err`=1, `frame_err`=0.
4. Send 0x55 with the stop bit forced 0. Required: `frame_err`=1, `break_det`=0. Then send all-zero data with a low stop bit. Required: `frame_err`=1, `break_det`=1, `dout`=0x00.
5. Assert `reset` during data bit 4. Required: outputs at reset values, no `valid`. After release, 0x81 is received with no errors.
6. STOP_BITS=2, MSB_FIRST=0. Send back-to-back frames 0x12 and 0x34 with no idle gap. Required: two `valid` pulses, `dout`=0x12 then 0x34, no errors.
